// File: rtl/mcu_pkg.sv
// Shared constants for the 12-bit microcontroller control unit:
// state encoding, opcode values, instruction-class masks and decode helpers.
package mcu_pkg;

   localparam logic [2:0] ST_LOAD    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_DECODE  = 3'd2;
   localparam logic [2:0] ST_EXECUTE = 3'd3;
   localparam logic [2:0] ST_HALTED  = 3'd4;

   localparam logic [3:0] OP_SYS = 4'b0000;
   localparam logic [3:0] OP_JMP = 4'b0001;
   localparam logic [3:0] OP_JZ  = 4'b0010;
   localparam logic [3:0] OP_JC  = 4'b0011;

   // Instruction class is identified by (IR[11:8] & MASK) == PFX
   localparam logic [3:0] MTYPE_MASK = 4'b1100;
   localparam logic [3:0] MTYPE_PFX  = 4'b0100;
   localparam logic [3:0] ITYPE_MASK = 4'b1000;
   localparam logic [3:0] ITYPE_PFX  = 4'b1000;

   localparam logic [7:0] HALT_IMM = 8'hFF;

   function automatic logic is_mtype(input logic [3:0] opc);
      return (opc & MTYPE_MASK) == MTYPE_PFX;
   endfunction

   function automatic logic is_itype(input logic [3:0] opc);
      return (opc & ITYPE_MASK) == ITYPE_PFX;
   endfunction

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction/state decode: produces memory, ALU and register
// strobes, IR field extracts, the branch-taken flag and the HALT detect.
module mcu_decode
   import mcu_pkg::*;
(
   input  logic [2:0]  state_i,
   input  logic [11:0] ir_i,
   input  logic        zero_i,
   input  logic        carry_i,
   output logic        pmem_load_o,
   output logic        dmem_en_o,
   output logic        dmem_wen_o,
   output logic [3:0]  dmem_addr_o,
   output logic [3:0]  alu_op_o,
   output logic        alu_src_o,
   output logic [7:0]  imm_o,
   output logic        acc_we_o,
   output logic        sr_we_o,
   output logic        halted_o,
   output logic        jump_o,
   output logic        halt_o
);

   logic [3:0] opc;
   logic       mtype;
   logic       itype;

   assign opc   = ir_i[11:8];
   assign mtype = is_mtype(opc);
   assign itype = is_itype(opc);

   // Field extracts follow IR at all times so unused outputs stay deterministic
   assign dmem_addr_o = ir_i[3:0];
   assign imm_o       = ir_i[7:0];
   assign alu_src_o   = itype;
   assign alu_op_o    = itype ? {1'b0, ir_i[10:8]} : ir_i[7:4];
   assign halt_o      = (opc == OP_SYS) && (ir_i[7:0] == HALT_IMM);

   always_comb begin
      jump_o = 1'b0;
      case (opc)
         OP_JMP:  jump_o = 1'b1;
         OP_JZ:   jump_o = zero_i;
         OP_JC:   jump_o = carry_i;
         default: jump_o = 1'b0;
      endcase
   end

   always_comb begin
      pmem_load_o = 1'b0;
      dmem_en_o   = 1'b0;
      dmem_wen_o  = 1'b0;
      acc_we_o    = 1'b0;
      sr_we_o     = 1'b0;
      halted_o    = 1'b0;
      case (state_i)
         ST_LOAD:   pmem_load_o = 1'b1;
         ST_DECODE: dmem_en_o   = mtype;
         ST_EXECUTE: begin
            if (mtype) begin
               dmem_en_o  = 1'b1;
               dmem_wen_o = ir_i[9];
               acc_we_o   = ~ir_i[9];
               sr_we_o    = 1'b1;
            end else if (itype) begin
               acc_we_o = 1'b1;
               sr_we_o  = 1'b1;
            end
         end
         ST_HALTED: halted_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mcu_ctrl.sv
// Multi-cycle control unit: holds state, PC and IR and sequences each
// instruction through FETCH, DECODE and EXECUTE.
module mcu_ctrl
   import mcu_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load_done,
   input  logic [11:0] i_instr,
   input  logic        i_zero,
   input  logic        i_carry,
   output logic [7:0]  o_pc,
   output logic        o_pmem_load,
   output logic        o_dmem_en,
   output logic        o_dmem_wen,
   output logic [3:0]  o_dmem_addr,
   output logic [3:0]  o_alu_op,
   output logic        o_alu_src,
   output logic [7:0]  o_imm,
   output logic        o_acc_we,
   output logic        o_sr_we,
   output logic        o_halted
);

   logic [2:0]  state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [11:0] ir_q, ir_d;

   logic dmem_wen, acc_we, sr_we;
   logic jump, halt;

   mcu_decode u_decode (
      .state_i     (state_q),
      .ir_i        (ir_q),
      .zero_i      (i_zero),
      .carry_i     (i_carry),
      .pmem_load_o (o_pmem_load),
      .dmem_en_o   (o_dmem_en),
      .dmem_wen_o  (dmem_wen),
      .dmem_addr_o (o_dmem_addr),
      .alu_op_o    (o_alu_op),
      .alu_src_o   (o_alu_src),
      .imm_o       (o_imm),
      .acc_we_o    (acc_we),
      .sr_we_o     (sr_we),
      .halted_o    (o_halted),
      .jump_o      (jump),
      .halt_o      (halt)
   );

   // Write strobes are masked while reset is held so a mid-EXECUTE reset writes nothing
   assign o_dmem_wen = dmem_wen & i_rst_n;
   assign o_acc_we   = acc_we & i_rst_n;
   assign o_sr_we    = sr_we & i_rst_n;
   assign o_pc       = pc_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         ST_LOAD: if (i_load_done) state_d = ST_FETCH;
         ST_FETCH: begin
            ir_d    = i_instr;
            state_d = ST_DECODE;
         end
         ST_DECODE: state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            pc_d    = jump ? ir_q[7:0] : pc_q + 8'd1;
            state_d = halt ? ST_HALTED : ST_FETCH;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_LOAD;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

endmodule

// File: tb/tb_mcu_ctrl.sv
// Self-checking bench for mcu_ctrl: a program table stepped one instruction at
// a time, a write-strobe scoreboard, and hand sequences for HALT and reset.
module tb_mcu_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_load_done;
   logic [11:0] i_instr;
   logic        i_zero;
   logic        i_carry;
   logic [7:0]  o_pc;
   logic        o_pmem_load;
   logic        o_dmem_en;
   logic        o_dmem_wen;
   logic [3:0]  o_dmem_addr;
   logic [3:0]  o_alu_op;
   logic        o_alu_src;
   logic [7:0]  o_imm;
   logic        o_acc_we;
   logic        o_sr_we;
   logic        o_halted;

   mcu_ctrl dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_load_done (i_load_done),
      .i_instr     (i_instr),
      .i_zero      (i_zero),
      .i_carry     (i_carry),
      .o_pc        (o_pc),
      .o_pmem_load (o_pmem_load),
      .o_dmem_en   (o_dmem_en),
      .o_dmem_wen  (o_dmem_wen),
      .o_dmem_addr (o_dmem_addr),
      .o_alu_op    (o_alu_op),
      .o_alu_src   (o_alu_src),
      .o_imm       (o_imm),
      .o_acc_we    (o_acc_we),
      .o_sr_we     (o_sr_we),
      .o_halted    (o_halted)
   );

   always #5 i_clk = ~i_clk;

   logic [11:0] pmem [256];
   logic [7:0]  dmem [16];
   logic [7:0]  wr_data;

   assign i_instr = pmem[o_pc];

   always @(posedge i_clk)
      if (o_dmem_en && o_dmem_wen) dmem[o_dmem_addr] <= wr_data;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] addr;
      logic [7:0] imm;
      logic       src;
      logic       wen;
      logic       acc;
      logic       sr;
      logic       en;
   } wr_t;

   typedef struct {
      logic [11:0] instr;
      logic        z;
      logic        c;
      logic [7:0]  pc;
      logic [7:0]  npc;
      logic        dec_en;
      logic        has_wr;
      wr_t         wr;
   } vec_t;

   int unsigned checks = 0;
   int unsigned errors = 0;
   wr_t         sbq [$];
   vec_t        vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [11:0] instr, input logic z, input logic c,
                               input logic [7:0] pc, input logic [7:0] npc,
                               input logic dec_en, input logic has_wr, input wr_t wr);
      vec_t v;
      v.instr = instr; v.z = z; v.c = c; v.pc = pc; v.npc = npc;
      v.dec_en = dec_en; v.has_wr = has_wr; v.wr = wr;
      return v;
   endfunction

   // Scoreboard: any register/memory write strobe must match the next expected write
   always @(negedge i_clk) begin
      if (i_rst_n && (o_acc_we || o_dmem_wen || o_sr_we)) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write: got pc=%0h expected no write", o_pc);
         end else begin
            wr_t e, a;
            e = sbq.pop_front();
            a = '{op: o_alu_op, addr: o_dmem_addr, imm: o_imm, src: o_alu_src,
                  wen: o_dmem_wen, acc: o_acc_we, sr: o_sr_we, en: o_dmem_en};
            if (a !== e) begin
               errors++;
               $display("FAIL sb_write: got %h expected %h", a, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) pmem[i] = '0;
      for (int i = 0; i < 16; i++) dmem[i] = '0;
      wr_data = 8'h5A;

      //            instr   z     c     pc     npc    dec   wr    {op,addr,imm,src,wen,acc,sr,en}
      vecs[0]  = mk(12'h000, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, '0);
      vecs[1]  = mk(12'h635, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1, 1'b1, '{4'h3, 4'h5, 8'h35, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      vecs[2]  = mk(12'h4A7, 1'b0, 1'b0, 8'h02, 8'h03, 1'b1, 1'b1, '{4'hA, 4'h7, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      vecs[3]  = mk(12'h5C2, 1'b0, 1'b0, 8'h03, 8'h04, 1'b1, 1'b1, '{4'hC, 4'h2, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
      vecs[4]  = mk(12'hA2C, 1'b0, 1'b0, 8'h04, 8'h05, 1'b0, 1'b1, '{4'h2, 4'hC, 8'h2C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      vecs[5]  = mk(12'hF80, 1'b0, 1'b0, 8'h05, 8'h06, 1'b0, 1'b1, '{4'h7, 4'h0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
      vecs[6]  = mk(12'h7B4, 1'b0, 1'b0, 8'h06, 8'h07, 1'b1, 1'b1, '{4'hB, 4'h4, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
      vecs[7]  = mk(12'h240, 1'b1, 1'b0, 8'h07, 8'h40, 1'b0, 1'b0, '0);
      vecs[8]  = mk(12'h240, 1'b0, 1'b1, 8'h40, 8'h41, 1'b0, 1'b0, '0);
      vecs[9]  = mk(12'h380, 1'b0, 1'b1, 8'h41, 8'h80, 1'b0, 1'b0, '0);
      vecs[10] = mk(12'h390, 1'b1, 1'b0, 8'h80, 8'h81, 1'b0, 1'b0, '0);
      vecs[11] = mk(12'h0F0, 1'b0, 1'b0, 8'h81, 8'h82, 1'b0, 1'b0, '0);
      vecs[12] = mk(12'h1FF, 1'b0, 1'b0, 8'h82, 8'hFF, 1'b0, 1'b0, '0);
      vecs[13] = mk(12'h1FF, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, '0);
      vecs[14] = mk(12'hA01, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, '{4'h2, 4'h1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});

      // Reset state
      i_rst_n = 1'b0; i_load_done = 1'b0; i_zero = 1'b0; i_carry = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("reset_outputs",
          32'({o_pc, o_pmem_load, o_dmem_en, o_dmem_wen, o_dmem_addr, o_alu_op,
               o_alu_src, o_imm, o_acc_we, o_sr_we, o_halted}),
          32'({8'h00, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
      i_rst_n = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      chk("load_hold", 32'(o_pmem_load), 32'(1'b1));
      i_load_done = 1'b1;
      @(posedge i_clk); @(negedge i_clk);
      chk("load_exit", 32'(o_pmem_load), 32'(1'b0));

      // Program table, one instruction per iteration, entered at FETCH
      for (int i = 0; i < 15; i++) begin
         pmem[vecs[i].pc] = vecs[i].instr;
         i_zero  = vecs[i].z;
         i_carry = vecs[i].c;
         chk($sformatf("pc_fetch[%0d]", i), 32'(o_pc), 32'(vecs[i].pc));
         chk($sformatf("fetch_idle[%0d]", i),
             32'({o_dmem_en, o_dmem_wen, o_acc_we, o_sr_we, o_halted, o_pmem_load}), 32'(0));
         if (vecs[i].has_wr) sbq.push_back(vecs[i].wr);
         @(posedge i_clk); @(negedge i_clk);
         chk($sformatf("dec_en[%0d]", i), 32'(o_dmem_en), 32'(vecs[i].dec_en));
         chk($sformatf("dec_nowr[%0d]", i), 32'({o_dmem_wen, o_acc_we, o_sr_we}), 32'(0));
         @(posedge i_clk); @(negedge i_clk);
         if (!vecs[i].has_wr)
            chk($sformatf("exe_idle[%0d]", i),
                32'({o_dmem_en, o_dmem_wen, o_acc_we, o_sr_we}), 32'(0));
         @(posedge i_clk); @(negedge i_clk);
         chk($sformatf("sb_drain[%0d]", i), 32'(sbq.size()), 32'(0));
         chk($sformatf("pc_next[%0d]", i), 32'(o_pc), 32'(vecs[i].npc));
         if (i == 1) chk("dmem_written", 32'(dmem[5]), 32'(8'h5A));
      end

      // HALT at PC 0
      pmem[8'h00] = 12'h0FF;
      pmem[8'h01] = 12'h180;
      @(posedge i_clk); @(negedge i_clk);
      @(posedge i_clk); @(negedge i_clk);
      chk("halt_exe", 32'({o_dmem_en, o_dmem_wen, o_acc_we, o_sr_we, o_halted}), 32'(0));
      @(posedge i_clk); @(negedge i_clk);
      chk("halted_flag", 32'(o_halted), 32'(1'b1));
      chk("halted_pc", 32'(o_pc), 32'(8'h01));
      begin
         int unsigned bad;
         bad = 0;
         for (int k = 0; k < 20; k++) begin
            @(posedge i_clk); @(negedge i_clk);
            if (o_pc !== 8'h01 || o_halted !== 1'b1 ||
                {o_dmem_en, o_dmem_wen, o_acc_we, o_sr_we, o_pmem_load} !== 5'b0) bad++;
         end
         chk("halt_frozen_cycles_bad", 32'(bad), 32'(0));
      end
      i_rst_n = 1'b0; i_load_done = 1'b0;
      @(posedge i_clk); @(negedge i_clk);
      chk("halt_reset", 32'({o_halted, o_pmem_load, o_pc}), 32'({1'b0, 1'b1, 8'h00}));

      // Reset asserted during the EXECUTE of an M-type write
      i_rst_n = 1'b1; i_load_done = 1'b1;
      pmem[8'h00] = 12'h635;
      wr_data = 8'hC3;
      @(posedge i_clk); @(negedge i_clk);
      chk("rst_mid_fetch_pc", 32'(o_pc), 32'(8'h00));
      @(posedge i_clk); @(negedge i_clk);
      chk("rst_mid_dec_en", 32'(o_dmem_en), 32'(1'b1));
      @(posedge i_clk);
      #1 i_rst_n = 1'b0;
      @(negedge i_clk);
      chk("rst_mid_nowrite", 32'({o_dmem_wen, o_acc_we, o_sr_we}), 32'(0));
      @(posedge i_clk); @(negedge i_clk);
      chk("rst_mid_dmem", 32'(dmem[5]), 32'(8'h5A));
      chk("rst_mid_state", 32'({o_pmem_load, o_pc}), 32'({1'b1, 8'h00}));
      i_rst_n = 1'b1;
      chk("sb_final_empty", 32'(sbq.size()), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
